// File: rtl/dmem_bridge.sv
// dmem_bridge: connects the core data-memory port to a request/ack bus.
// Stores are posted into a one-entry write buffer. Loads stall the core until
// the data returns. A load that arrives while a store is on the bus is held
// and issued only after that store completes, so a read never passes a write.
module dmem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_mem_w_addr,
  input  logic [31:0] d_mem_w_data,
  input  logic        d_mem_we,
  input  logic        d_mem_oe,
  output logic [31:0] d_mem_r_data,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RAW} state_t;

  // Compare against TIMEOUT-1 because cnt_q is 0 in the first request cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [29:0] raddr_q, raddr_d;

  logic        ack;
  logic        to_hit;
  logic        load_only;

  // Next-state, bus-drive and timeout logic.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    raddr_d     = raddr_q;
    cnt_d       = bus_req_q ? cnt_q + 8'd1 : 8'd0;

    // An ack only counts while a request is out. If an ack and the timeout
    // land in the same cycle, the ack wins.
    ack       = bus_ack & bus_req_q;
    to_hit    = bus_req_q & ~bus_ack & (cnt_q == TO_LAST);
    load_only = d_mem_oe & ~d_mem_we;

    case (state_q)
      IDLE: begin
        if (d_mem_we) begin
          state_d     = WRITE;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = d_mem_w_addr[31:2];
          bus_wdata_d = d_mem_w_data;
          cnt_d       = 8'd0;
        end else if (d_mem_oe) begin
          state_d    = READ;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = d_mem_w_addr[31:2];
          cnt_d      = 8'd0;
        end
      end
      WRITE: begin
        if (ack || to_hit) begin
          bus_req_d = 1'b0;
          cnt_d     = 8'd0;
          if (to_hit) err_d = 1'b1;
          // A load that arrives in the cycle the store completes goes
          // straight to READ. READ raises the request on the next cycle.
          if (load_only) begin
            raddr_d = d_mem_w_addr[31:2];
            state_d = READ;
          end else begin
            state_d = IDLE;
          end
        end else if (load_only) begin
          raddr_d = d_mem_w_addr[31:2];
          state_d = RAW;
        end
      end
      RAW: begin
        // A store that times out still releases the pending load. Dropping
        // the load here would leave the core stalled for good.
        if (ack || to_hit) begin
          bus_req_d = 1'b0;
          cnt_d     = 8'd0;
          if (to_hit) err_d = 1'b1;
          state_d   = READ;
        end
      end
      READ: begin
        if (!bus_req_q) begin
          // Issue the load that was held behind a store.
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = raddr_q;
          cnt_d      = 8'd0;
        end else if (ack) begin
          rdata_d   = bus_rdata;
          bus_req_d = 1'b0;
          cnt_d     = 8'd0;
          state_d   = IDLE;
        end else if (to_hit) begin
          rdata_d   = 32'hDEADBEEF;
          err_d     = 1'b1;
          bus_req_d = 1'b0;
          cnt_d     = 8'd0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      raddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      raddr_q     <= raddr_d;
    end
  end

  // Stall the core while a load is outstanding. A load in IDLE stalls in the
  // same cycle. A store stalls only when the write buffer is still busy.
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      IDLE:     mem_stall = load_only;
      WRITE:    mem_stall = d_mem_we | d_mem_oe;
      RAW:      mem_stall = 1'b1;
      READ:     mem_stall = 1'b1;
      default:  mem_stall = 1'b0;
    endcase
  end

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign d_mem_r_data = rdata_q;
  assign bus_err      = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge, built with TIMEOUT=8.
// Inputs are driven 1ns after the rising edge. Outputs are sampled 2ns later.
module tb_dmem_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] d_mem_w_addr = '0;
  logic [31:0] d_mem_w_data = '0;
  logic        d_mem_we = 1'b0;
  logic        d_mem_oe = 1'b0;
  logic [31:0] d_mem_r_data;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  dmem_bridge #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .d_mem_w_addr(d_mem_w_addr), .d_mem_w_data(d_mem_w_data),
    .d_mem_we(d_mem_we), .d_mem_oe(d_mem_oe),
    .d_mem_r_data(d_mem_r_data), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall"}, 32'(mem_stall), 32'd0);
    chk({tag, ".req"},   32'(bus_req),   32'd0);
    chk({tag, ".we"},    32'(bus_we),    32'd0);
    chk({tag, ".addr"},  32'(bus_addr),  32'd0);
    chk({tag, ".wdata"}, bus_wdata,      32'd0);
    chk({tag, ".rdata"}, d_mem_r_data,   32'd0);
    chk({tag, ".err"},   32'(bus_err),   32'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick(); #2;
    chk_all_zero("rst");
    tick(); rst = 1'b1;

    // Posted store, 0x100 / 0xCAFEF00D, ack in the 3rd request cycle
    tick(); d_mem_we = 1; d_mem_w_addr = 32'h100; d_mem_w_data = 32'hCAFEF00D; #2;
    chk("st.c0.stall", 32'(mem_stall), 0);
    chk("st.c0.req", 32'(bus_req), 0);
    tick(); d_mem_we = 0; d_mem_w_addr = 0; d_mem_w_data = 0; #2;
    chk("st.c1.req", 32'(bus_req), 1);
    chk("st.c1.we", 32'(bus_we), 1);
    chk("st.c1.addr", 32'(bus_addr), 32'h40);
    chk("st.c1.wdata", bus_wdata, 32'hCAFEF00D);
    chk("st.c1.stall", 32'(mem_stall), 0);
    tick(); #2;
    chk("st.c2.addr", 32'(bus_addr), 32'h40);
    chk("st.c2.req", 32'(bus_req), 1);
    tick(); bus_ack = 1; #2;
    chk("st.c3.req", 32'(bus_req), 1);
    chk("st.c3.stall", 32'(mem_stall), 0);
    tick(); bus_ack = 0; #2;
    chk("st.c4.req", 32'(bus_req), 0);
    chk("st.c4.stall", 32'(mem_stall), 0);

    // Zero-wait load: stall lasts exactly 2 cycles
    tick(); d_mem_oe = 1; d_mem_w_addr = 32'h204; #2;
    chk("ld.c0.stall", 32'(mem_stall), 1);
    tick(); d_mem_oe = 0; bus_ack = 1; bus_rdata = 32'h12345678; #2;
    chk("ld.c1.stall", 32'(mem_stall), 1);
    chk("ld.c1.req", 32'(bus_req), 1);
    chk("ld.c1.we", 32'(bus_we), 0);
    chk("ld.c1.addr", 32'(bus_addr), 32'h81);
    tick(); bus_ack = 0; bus_rdata = 0; #2;
    chk("ld.c2.stall", 32'(mem_stall), 0);
    chk("ld.c2.req", 32'(bus_req), 0);
    chk("ld.c2.rdata", d_mem_r_data, 32'h12345678);

    // Store 0x10 followed by a load of 0x10. The write is acked in its 4th cycle.
    tick(); d_mem_we = 1; d_mem_w_addr = 32'h10; d_mem_w_data = 32'hA5A5A5A5; #2;
    chk("raw.c0.stall", 32'(mem_stall), 0);
    tick(); d_mem_we = 0; d_mem_oe = 1; #2;
    chk("raw.c1.stall", 32'(mem_stall), 1);
    chk("raw.c1.we", 32'(bus_we), 1);
    tick(); d_mem_oe = 0; d_mem_w_addr = 0; #2;
    chk("raw.c2.stall", 32'(mem_stall), 1);
    chk("raw.c2.we", 32'(bus_we), 1);
    tick(); #2;
    chk("raw.c3.stall", 32'(mem_stall), 1);
    chk("raw.c3.req", 32'(bus_req), 1);
    tick(); bus_ack = 1; #2;
    chk("raw.c4.we", 32'(bus_we), 1);
    chk("raw.c4.wdata", bus_wdata, 32'hA5A5A5A5);
    // A stray ack while no request is out must be ignored.
    tick(); bus_rdata = 32'hFFFFFFFF; #2;
    chk("raw.c5.stall", 32'(mem_stall), 1);
    chk("raw.c5.req", 32'(bus_req), 0);
    tick(); bus_rdata = 32'h55AA1234; #2;
    chk("raw.c6.req", 32'(bus_req), 1);
    chk("raw.c6.we", 32'(bus_we), 0);
    chk("raw.c6.addr", 32'(bus_addr), 32'h4);
    chk("raw.c6.stall", 32'(mem_stall), 1);
    tick(); bus_ack = 0; bus_rdata = 0; #2;
    chk("raw.c7.stall", 32'(mem_stall), 0);
    chk("raw.c7.rdata", d_mem_r_data, 32'h55AA1234);

    // Ack in the same cycle as the timeout (8th request cycle): the ack wins.
    tick(); d_mem_oe = 1; d_mem_w_addr = 32'h400; #2;
    tick(); d_mem_oe = 0; #2;
    for (int i = 0; i < 6; i++) tick();
    tick(); bus_ack = 1; bus_rdata = 32'h77778888; #2;
    chk("race.c8.req", 32'(bus_req), 1);
    tick(); bus_ack = 0; bus_rdata = 0; #2;
    chk("race.err", 32'(bus_err), 0);
    chk("race.rdata", d_mem_r_data, 32'h77778888);
    chk("race.stall", 32'(mem_stall), 0);

    // Load with no ack: the request times out after 8 cycles.
    tick(); d_mem_oe = 1; d_mem_w_addr = 32'h300; #2;
    tick(); d_mem_oe = 0; #2;
    chk("to.c1.req", 32'(bus_req), 1);
    for (int i = 2; i <= 8; i++) begin
      tick(); #2;
      chk($sformatf("to.c%0d.req", i), 32'(bus_req), 1);
    end
    chk("to.c8.err", 32'(bus_err), 0);
    tick(); #2;
    chk("to.c9.req", 32'(bus_req), 0);
    chk("to.c9.err", 32'(bus_err), 1);
    chk("to.c9.rdata", d_mem_r_data, 32'hDEADBEEF);
    chk("to.c9.stall", 32'(mem_stall), 0);

    // Back-to-back stores. The core holds the 2nd store while stalled.
    tick(); d_mem_we = 1; d_mem_w_addr = 32'h20; d_mem_w_data = 32'h11111111; #2;
    chk("ss.c0.stall", 32'(mem_stall), 0);
    tick(); d_mem_w_addr = 32'h24; d_mem_w_data = 32'h22222222; #2;
    chk("ss.c1.stall", 32'(mem_stall), 1);
    chk("ss.c1.addr", 32'(bus_addr), 32'h8);
    chk("ss.c1.wdata", bus_wdata, 32'h11111111);
    tick(); bus_ack = 1; #2;
    chk("ss.c2.stall", 32'(mem_stall), 1);
    tick(); bus_ack = 0; #2;
    chk("ss.c3.stall", 32'(mem_stall), 0);
    chk("ss.c3.req", 32'(bus_req), 0);
    tick(); d_mem_we = 0; d_mem_w_addr = 0; d_mem_w_data = 0; bus_ack = 1; #2;
    chk("ss.c4.req", 32'(bus_req), 1);
    chk("ss.c4.we", 32'(bus_we), 1);
    chk("ss.c4.addr", 32'(bus_addr), 32'h9);
    chk("ss.c4.wdata", bus_wdata, 32'h22222222);
    tick(); bus_ack = 0; #2;
    chk("ss.c5.req", 32'(bus_req), 0);
    chk("ss.err.sticky", 32'(bus_err), 1);

    // Reset asserted while a read is waiting on the bus.
    tick(); d_mem_oe = 1; d_mem_w_addr = 32'h500; #2;
    tick(); d_mem_oe = 0; d_mem_w_addr = 0; #2;
    tick(); #2;
    chk("mr.pre.req", 32'(bus_req), 1);
    rst = 1'b0; #1;
    chk_all_zero("mr");
    tick(); tick(); rst = 1'b1;
    tick(); #2;
    chk("mr.post.req", 32'(bus_req), 0);
    chk("mr.post.stall", 32'(mem_stall), 0);
    tick(); d_mem_oe = 1; d_mem_w_addr = 32'h600; #2;
    chk("mr.ld.c0.stall", 32'(mem_stall), 1);
    tick(); d_mem_oe = 0; d_mem_w_addr = 0; bus_ack = 1; bus_rdata = 32'h600D600D; #2;
    chk("mr.ld.c1.addr", 32'(bus_addr), 32'h180);
    tick(); bus_ack = 0; bus_rdata = 0; #2;
    chk("mr.ld.rdata", d_mem_r_data, 32'h600D600D);
    chk("mr.ld.stall", 32'(mem_stall), 0);
    chk("mr.ld.err", 32'(bus_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
